// File: rtl/fir_ctrl_pkg.sv
// Shared types, defaults and helpers for the time-multiplexed FIR sequencer.
package fir_ctrl_pkg;

    // Sequencer phases: idle, shift/flush, coefficient sweep, MAC pipeline drain, result hold.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        DRAIN,
        OUT
    } fir_state_e;

    localparam int DEF_TAPS     = 64;
    localparam int DEF_MAC_LAT  = 2;
    localparam int DEF_CHANNELS = 1;

    // A zero or out-of-range runtime tap count falls back to the full ROM depth.
    function automatic int unsigned eff_taps(input int unsigned taps_cfg, input int unsigned taps);
        return ((taps_cfg == 0) || (taps_cfg > taps)) ? taps : taps_cfg;
    endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Sample-in / result-out handshake plus datapath control bundle of the FIR sequencer.
interface fir_seq_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int CH_W   = 1
);
    logic              inputValid;
    logic              inputReady;
    logic [CH_W-1:0]   inputChannel;
    logic [ADDR_W:0]   tapsCfg;
    logic              shift;
    logic              flush;
    logic              macEn;
    logic [ADDR_W-1:0] address;
    logic [CH_W-1:0]   channel;
    logic              outputValid;
    logic              outputReady;
    logic [CH_W-1:0]   outputChannel;
    logic              busy;

    // Sequencer side.
    modport master (
        input  inputValid, inputChannel, tapsCfg, outputReady,
        output inputReady, shift, flush, macEn, address, channel,
               outputValid, outputChannel, busy
    );

    // Producer / datapath / consumer side.
    modport slave (
        output inputValid, inputChannel, tapsCfg, outputReady,
        input  inputReady, shift, flush, macEn, address, channel,
               outputValid, outputChannel, busy
    );
endinterface

// File: rtl/tap_addr_counter.sv
// Loadable up-counter with clear/enable and a terminal flag (count == limit).
// Saturates at the limit; it never wraps.
module tap_addr_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] limit_i,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         term_o
);
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] limit_q, limit_d;

    assign count_o = count_q;
    assign term_o  = (count_q == limit_q);

    // Next count: load restarts at zero with a new limit; clear restarts only; enable steps.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        limit_d = limit_q;
        if (load_i) begin
            count_d = '0;
            limit_d = limit_i;
        end else if (clear_i) begin
            count_d = '0;
        end else if (en_i && !term_o) begin
            count_d = count_q + W'(1);
        end
    end

    // Count and limit registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
        if (rst) begin
            count_q <= '0;
            limit_q <= '0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
        end
    end
endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for a time-multiplexed FIR: per accepted sample it shifts/flushes, sweeps
// the coefficient addresses with the MAC enabled, waits out the MAC pipeline and then
// holds the channel-tagged result under a valid/ready handshake.
module fir_seq_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int TAPS     = DEF_TAPS,
    parameter int ADDR_W   = $clog2(TAPS),
    parameter int MAC_LAT  = DEF_MAC_LAT,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input logic           clk,
    input logic           rst,
    fir_seq_ctrl_if.master bus
);
    // One counter serves both the tap sweep (limit N-1) and the drain wait (limit MAC_LAT-1).
    localparam int DRAIN_W    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam int CNT_W      = (ADDR_W > DRAIN_W) ? ADDR_W : DRAIN_W;
    localparam int DRAIN_LAST = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;

    fir_state_e        state_q, state_d;
    logic              accept;
    logic              in_ready;
    logic              cnt_load, cnt_clear, cnt_en, cnt_term;
    logic [CNT_W-1:0]  cnt_limit, cnt;
    logic [ADDR_W-1:0] taps_last;
    logic [ADDR_W-1:0] n_last_q, n_last_d;
    logic [CH_W-1:0]   channel_q, channel_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;

    // Last tap index of the offered sample; only latched on the accept edge.
    assign taps_last = ADDR_W'(eff_taps(32'(bus.tapsCfg), TAPS) - 1);

    // Ready in IDLE, or in OUT when the current result is being consumed this cycle.
    assign in_ready = (state_q == IDLE) || ((state_q == OUT) && bus.outputReady);
    assign accept   = bus.inputValid && in_ready;

    tap_addr_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load_i  (cnt_load),
        .limit_i (cnt_limit),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .count_o (cnt),
        .term_o  (cnt_term)
    );

    // Next-state and counter control.
    always_comb begin
        state_d   = state_q;
        cnt_load  = accept;
        cnt_limit = CNT_W'(taps_last);
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = LOAD;
            end
            LOAD: begin
                state_d = MAC;
            end
            MAC: begin
                cnt_en = 1'b1;
                if (cnt_term) begin
                    if (MAC_LAT > 0) begin
                        state_d   = DRAIN;
                        cnt_load  = 1'b1;
                        cnt_limit = CNT_W'(DRAIN_LAST);
                    end else begin
                        state_d = OUT;
                    end
                end
            end
            DRAIN: begin
                cnt_en = 1'b1;
                if (cnt_term) state_d = OUT;
            end
            OUT: begin
                if (accept) begin
                    state_d = LOAD;
                end else if (bus.outputReady) begin
                    state_d   = IDLE;
                    cnt_clear = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-sample context: tap limit and channel latched on accept; result tag captured entering OUT.
    always_comb begin
        n_last_d  = accept ? taps_last : n_last_q;
        channel_d = accept ? bus.inputChannel : channel_q;
        out_ch_d  = ((state_d == OUT) && (state_q != OUT)) ? channel_q : out_ch_q;
    end

    // State and context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_last_q  <= '0;
            channel_q <= '0;
            out_ch_q  <= '0;
        end else begin
            state_q   <= state_d;
            n_last_q  <= n_last_d;
            channel_q <= channel_d;
            out_ch_q  <= out_ch_d;
        end
    end

    // Outputs decoded from registered state; address holds the last tap after the sweep.
    assign bus.inputReady    = in_ready;
    assign bus.shift         = (state_q == LOAD);
    assign bus.flush         = (state_q == LOAD);
    assign bus.macEn         = (state_q == MAC);
    assign bus.outputValid   = (state_q == OUT);
    assign bus.busy          = (state_q != IDLE);
    assign bus.channel       = channel_q;
    assign bus.outputChannel = out_ch_q;
    assign bus.address       = ((state_q == DRAIN) || (state_q == OUT)) ? n_last_q : ADDR_W'(cnt);

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench: the driver pushes the expected result of each accepted sample,
// a negedge monitor pops and compares whenever a result is presented.
module tb_fir_seq_ctrl;
    localparam int TAPS     = 16;
    localparam int ADDR_W   = 4;
    localparam int CW       = ADDR_W + 1;
    localparam int MAC_LAT  = 2;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;
    localparam int T0_TAPS  = 8;
    localparam int T0_AW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fir_seq_ctrl_if #(.ADDR_W(ADDR_W), .CH_W(CH_W)) bus ();
    fir_seq_ctrl_if #(.ADDR_W(T0_AW), .CH_W(1)) bus0 ();

    fir_seq_ctrl #(
        .TAPS(TAPS), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT), .CHANNELS(CHANNELS), .CH_W(CH_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fir_seq_ctrl #(
        .TAPS(T0_TAPS), .ADDR_W(T0_AW), .MAC_LAT(0), .CHANNELS(1), .CH_W(1)
    ) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    typedef struct {
        int ch;
        int n;
        int k;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: effective tap count from the runtime configuration.
    function automatic int model_n(input int cfg, input int taps);
        if (cfg == 0 || cfg > taps) return taps;
        return cfg;
    endfunction

    // One clock of stimulus on the main DUT; reports whether the sample is taken at the next edge.
    task automatic drive(input bit v, input int ch, input int cfg, input bit ordy, output bit acc);
        @(posedge clk);
        #1;
        bus.inputValid   = v;
        bus.inputChannel = CH_W'(ch);
        bus.tapsCfg      = CW'(cfg);
        bus.outputReady  = ordy;
        @(negedge clk);
        acc = v && bus.inputReady && !rst;
        if (acc) sb_q.push_back('{ch: ch, n: model_n(cfg, TAPS), k: cyc + 1});
    endtask

    task automatic wait_idle(input int limit);
        bit acc;
        for (int c = 0; c < limit; c++) begin
            drive(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), 1'b1, acc);
            if (!bus.busy && sb_q.size() == 0) break;
        end
        check("idle_reached", bus.busy, 0);
        check("sb_drained", sb_q.size(), 0);
    endtask

    // Monitor state.
    bit m_in_out = 0, m_prev_stall = 0, m_expect_idle = 0, m_addr_bad = 0;
    int m_mac_cnt = 0, m_prev_ch = 0;
    exp_t m_e;

    always @(negedge clk) begin
        if (rst) begin
            m_in_out = 0; m_prev_stall = 0; m_expect_idle = 0; m_addr_bad = 0; m_mac_cnt = 0;
        end else begin
            check("in_ready", bus.inputReady, int'(!bus.busy || (bus.outputValid && bus.outputReady)));
            if (m_expect_idle) check("idle_after_out", bus.busy, 0);
            m_expect_idle = 0;
            if (m_prev_stall) begin
                check("stall_valid", bus.outputValid, 1);
                check("stall_channel", bus.outputChannel, m_prev_ch);
                check("stall_no_shift", bus.shift, 0);
            end
            if (bus.shift) begin
                check("load_flush", bus.flush, 1);
                check("load_addr", bus.address, 0);
                check("load_mac_off", bus.macEn, 0);
                m_mac_cnt = 0;
                m_addr_bad = 0;
            end
            if (bus.macEn) begin
                if (bus.address != m_mac_cnt) m_addr_bad = 1;
                m_mac_cnt++;
            end
            if (bus.busy && !bus.shift && !bus.macEn && !bus.outputValid && sb_q.size() > 0)
                check("drain_addr", bus.address, sb_q[0].n - 1);
            if (bus.outputValid && !m_in_out) begin
                m_in_out = 1;
                check("out_expected", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    m_e = sb_q[0];
                    check("out_channel", bus.outputChannel, m_e.ch);
                    check("out_latency", cyc, m_e.k + m_e.n + MAC_LAT + 1);
                    check("mac_len", m_mac_cnt, m_e.n);
                    check("mac_addr_seq", m_addr_bad, 0);
                end
            end
            if (bus.outputValid && bus.outputReady) begin
                m_in_out = 0;
                if (sb_q.size() > 0) void'(sb_q.pop_front());
                m_expect_idle = !bus.inputValid;
            end
            m_prev_stall = bus.outputValid && !bus.outputReady;
            m_prev_ch    = int'(bus.outputChannel);
        end
    end

    // Directed run on the zero-latency build.
    task automatic run_lat0(input int cfg, input int exp_n);
        int k, mc, first;
        bit bad;
        @(posedge clk);
        #1;
        bus0.inputValid = 1'b1; bus0.tapsCfg = 4'(cfg); bus0.outputReady = 1'b1;
        @(negedge clk);
        check("l0_ready", bus0.inputReady, 1);
        k = cyc + 1;
        @(posedge clk);
        #1;
        bus0.inputValid = 1'b0;
        mc = 0; bad = 0; first = -1;
        for (int i = 0; i < 40 && first < 0; i++) begin
            @(negedge clk);
            if (bus0.macEn) begin
                if (bus0.address != T0_AW'(mc)) bad = 1;
                mc++;
            end
            if (bus0.outputValid) first = cyc;
        end
        check("l0_mac_len", mc, exp_n);
        check("l0_addr_seq", bad, 0);
        check("l0_latency", first, k + exp_n + 1);
        @(negedge clk);
        check("l0_idle", bus0.busy, 0);
    endtask

    initial begin
        bit acc;
        int seq[3] = '{2, 0, 3};
        int idx;
        bus.inputValid = 0; bus.inputChannel = 0; bus.tapsCfg = 0; bus.outputReady = 0;
        bus0.inputValid = 0; bus0.inputChannel = 0; bus0.tapsCfg = 0; bus0.outputReady = 0;

        // Reset state.
        #12;
        check("rst_shift", bus.shift, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_mac", bus.macEn, 0);
        check("rst_valid", bus.outputValid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_addr", bus.address, 0);
        check("rst_channel", bus.channel, 0);
        check("rst_out_ch", bus.outputChannel, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("rdy_after_rst", bus.inputReady, 1);

        // Single full-length sample.
        drive(1'b1, 0, 0, 1'b1, acc);
        check("single_accept", acc, 1);
        wait_idle(100);

        // Back-to-back with inputValid held high, channels 2,0,3.
        idx = 0;
        for (int c = 0; c < 300 && idx < 3; c++) begin
            drive(1'b1, seq[idx], 0, 1'b1, acc);
            if (acc) idx++;
        end
        check("b2b_accepts", idx, 3);
        wait_idle(100);

        // Backpressure in OUT.
        drive(1'b1, 1, 5, 1'b0, acc);
        check("bp_accept", acc, 1);
        for (int c = 0; c < 60; c++) begin
            drive(1'b0, 0, 0, 1'b0, acc);
            if (bus.outputValid) break;
        end
        check("bp_out", bus.outputValid, 1);
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 2, 3, 1'b0, acc);
            check("bp_no_accept", acc, 0);
        end
        drive(1'b0, 0, 0, 1'b1, acc);
        wait_idle(20);

        // Asynchronous reset mid-sweep.
        drive(1'b1, 3, 0, 1'b1, acc);
        for (int c = 0; c < 40; c++) begin
            drive(1'b0, 0, 0, 1'b1, acc);
            if (bus.macEn && bus.address == 10) break;
        end
        check("rst_mid_addr", bus.address, 10);
        #2 rst = 1'b1;
        #1;
        check("arst_mac", bus.macEn, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_addr", bus.address, 0);
        check("arst_channel", bus.channel, 0);
        check("arst_valid", bus.outputValid, 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 30; c++) drive(1'b0, 0, 0, 1'b1, acc);
        check("arst_stays_idle", bus.busy, 0);
        drive(1'b1, 1, 7, 1'b1, acc);
        check("post_rst_accept", acc, 1);
        wait_idle(60);

        // Offers and tapsCfg changes while sweeping are ignored.
        drive(1'b1, 2, 6, 1'b1, acc);
        check("e_accept", acc, 1);
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), 1'b1, acc);
            check("busy_no_accept", acc, 0);
        end
        wait_idle(60);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            int sel, cfg;
            sel = int'($urandom_range(0, 3));
            if (sel == 0) cfg = 0;
            else if (sel == 1) cfg = int'($urandom_range(TAPS + 1, 31));
            else cfg = int'($urandom_range(1, TAPS));
            drive($urandom_range(0, 2) != 0, int'($urandom_range(0, CHANNELS - 1)), cfg,
                  $urandom_range(0, 3) != 0, acc);
        end
        wait_idle(300);

        // Zero-latency build: short and out-of-range tap counts.
        run_lat0(5, 5);
        run_lat0(12, T0_TAPS);

        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
